// File: rtl/ahb_write_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_write_regfile
//  Description : AHB-Lite write-only slave for the encryption core. It decodes
//                pipelined word writes into indexed key, nonce, destination
//                and plain-text registers. A completed text block is announced
//                with a one-cycle text_valid pulse. Text writes are held off
//                with wait states while the downstream FIFO is full. Illegal
//                writes get a two-cycle ERROR response.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    HCLK, HRESETn     bus clock, asynchronous active-low reset
//    HSELx, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA
//                      AHB-Lite slave inputs (only HADDR[7:0] is decoded)
//    fifo_full         downstream text FIFO is full
//    key, nonce, destination, plain_text
//                      configuration / data registers
//    text_valid        one-cycle pulse: plain_text holds a complete block
//    HREADYOUT, HRESP  AHB-Lite slave response
// ============================================================================
module ahb_write_regfile #(
    parameter int         DATA_W      = 32,
    parameter int         KEY_WORDS   = 4,
    parameter int         NONCE_WORDS = 4,
    parameter int         TEXT_WORDS  = 4,
    parameter logic [7:0] KEY_BASE    = 8'h04,
    parameter logic [7:0] NONCE_BASE  = 8'h14,
    parameter logic [7:0] DEST_BASE   = 8'h24,
    parameter logic [7:0] TEXT_BASE   = 8'h34
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    input  logic                            HSELx,
    input  logic [31:0]                     HADDR,
    input  logic [1:0]                      HTRANS,
    input  logic                            HWRITE,
    input  logic [2:0]                      HSIZE,
    input  logic                            HREADY,
    input  logic [DATA_W-1:0]               HWDATA,
    input  logic                            fifo_full,
    output logic [KEY_WORDS*DATA_W-1:0]     key,
    output logic [NONCE_WORDS*DATA_W-1:0]   nonce,
    output logic [DATA_W-1:0]               destination,
    output logic [TEXT_WORDS*DATA_W-1:0]    plain_text,
    output logic                            text_valid,
    output logic                            HREADYOUT,
    output logic                            HRESP
);

    // ------------------------------------------------------------------
    // Address map
    // ------------------------------------------------------------------
    localparam int c_KEY_END   = int'(KEY_BASE)   + 4 * KEY_WORDS;
    localparam int c_NONCE_END = int'(NONCE_BASE) + 4 * NONCE_WORDS;
    localparam int c_DEST_END  = int'(DEST_BASE)  + 4;
    localparam int c_TEXT_END  = int'(TEXT_BASE)  + 4 * TEXT_WORDS;

    localparam logic [8:0] c_KEY_LO   = 9'(KEY_BASE);
    localparam logic [8:0] c_KEY_HI   = 9'(c_KEY_END);
    localparam logic [8:0] c_NONCE_LO = 9'(NONCE_BASE);
    localparam logic [8:0] c_NONCE_HI = 9'(c_NONCE_END);
    localparam logic [8:0] c_DEST_LO  = 9'(DEST_BASE);
    localparam logic [8:0] c_DEST_HI  = 9'(c_DEST_END);
    localparam logic [8:0] c_TEXT_LO  = 9'(TEXT_BASE);
    localparam logic [8:0] c_TEXT_HI  = 9'(c_TEXT_END);

    localparam int         c_IDX_W     = 6;
    localparam logic [c_IDX_W-1:0] c_TEXT_LAST = c_IDX_W'(TEXT_WORDS - 1);

    localparam logic [1:0] c_RGN_KEY   = 2'd0;
    localparam logic [1:0] c_RGN_NONCE = 2'd1;
    localparam logic [1:0] c_RGN_DEST  = 2'd2;
    localparam logic [1:0] c_RGN_TEXT  = 2'd3;

    function automatic bit f_overlap(input int a_lo, input int a_hi,
                                     input int b_lo, input int b_hi);
        return (a_lo < b_hi) && (b_lo < a_hi);
    endfunction

    generate
        if (DATA_W != 32) begin : g_bad_width
            $error("ahb_write_regfile: DATA_W must be 32");
        end
        if (f_overlap(int'(KEY_BASE),   c_KEY_END,   int'(NONCE_BASE), c_NONCE_END) ||
            f_overlap(int'(KEY_BASE),   c_KEY_END,   int'(DEST_BASE),  c_DEST_END)  ||
            f_overlap(int'(KEY_BASE),   c_KEY_END,   int'(TEXT_BASE),  c_TEXT_END)  ||
            f_overlap(int'(NONCE_BASE), c_NONCE_END, int'(DEST_BASE),  c_DEST_END)  ||
            f_overlap(int'(NONCE_BASE), c_NONCE_END, int'(TEXT_BASE),  c_TEXT_END)  ||
            f_overlap(int'(DEST_BASE),  c_DEST_END,  int'(TEXT_BASE),  c_TEXT_END)  ||
            (c_KEY_END > 256) || (c_NONCE_END > 256) ||
            (c_DEST_END > 256) || (c_TEXT_END > 256)) begin : g_bad_map
            $error("ahb_write_regfile: register regions overlap or exceed the 8-bit offset space");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    logic [8:0]         w_off;
    logic [8:0]         w_diff;
    logic [1:0]         w_region;
    logic [c_IDX_W-1:0] w_index;
    logic               w_hit;
    logic               w_legal;
    logic               w_accept;
    logic               w_unused;

    assign w_off = {1'b0, HADDR[7:0]};

    always_comb begin
        w_hit    = 1'b1;
        w_region = c_RGN_KEY;
        w_diff   = w_off - c_KEY_LO;
        if (w_off >= c_KEY_LO && w_off < c_KEY_HI) begin
            w_region = c_RGN_KEY;
            w_diff   = w_off - c_KEY_LO;
        end else if (w_off >= c_NONCE_LO && w_off < c_NONCE_HI) begin
            w_region = c_RGN_NONCE;
            w_diff   = w_off - c_NONCE_LO;
        end else if (w_off >= c_DEST_LO && w_off < c_DEST_HI) begin
            w_region = c_RGN_DEST;
            w_diff   = w_off - c_DEST_LO;
        end else if (w_off >= c_TEXT_LO && w_off < c_TEXT_HI) begin
            w_region = c_RGN_TEXT;
            w_diff   = w_off - c_TEXT_LO;
        end else begin
            w_hit    = 1'b0;
        end
    end

    assign w_index  = w_diff[7:2];
    assign w_accept = HSELx & HREADY & HTRANS[1] & HWRITE;
    assign w_legal  = w_hit & (HSIZE == 3'b010) & (HADDR[1:0] == 2'b00);
    assign w_unused = ^{HADDR[31:8], HTRANS[0], w_diff[8], w_diff[1:0]};

    // Address-phase info is kept until the matching data phase commits.
    logic [1:0]         r_region;
    logic [c_IDX_W-1:0] r_index;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_region <= c_RGN_KEY;
            r_index  <= '0;
        end else if (w_accept) begin
            r_region <= w_region;
            r_index  <= w_index;
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DATA  = 3'd1,
        S_STALL = 3'd2,
        S_ERR1  = 3'd3,
        S_ERR2  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;
    state_t w_follow;
    logic   w_blocked;
    logic   w_commit;

    // State that the concurrent address phase leads to once this cycle completes.
    assign w_follow  = w_accept ? (w_legal ? S_DATA : S_ERR1) : S_IDLE;
    assign w_blocked = (r_region == c_RGN_TEXT) & fifo_full;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        w_commit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = w_follow;
            end
            S_DATA, S_STALL: begin
                if (w_blocked) begin
                    HREADYOUT = 1'b0;
                    w_next    = S_STALL;
                end else begin
                    w_commit  = 1'b1;
                    w_next    = w_follow;
                end
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                w_next    = S_ERR2;
            end
            S_ERR2: begin
                HRESP     = 1'b1;
                w_next    = w_follow;
            end
            default: begin
                w_next    = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [KEY_WORDS*DATA_W-1:0]   r_key;
    logic [NONCE_WORDS*DATA_W-1:0] r_nonce;
    logic [DATA_W-1:0]             r_dest;
    logic [TEXT_WORDS*DATA_W-1:0]  r_text;
    logic                          r_text_valid;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_key        <= '0;
            r_nonce      <= '0;
            r_dest       <= '0;
            r_text       <= '0;
            r_text_valid <= 1'b0;
        end else begin
            // Pulse lands together with the last word of the block.
            r_text_valid <= w_commit & (r_region == c_RGN_TEXT) & (r_index == c_TEXT_LAST);
            if (w_commit) begin
                case (r_region)
                    c_RGN_KEY: begin
                        for (int i = 0; i < KEY_WORDS; i++) begin
                            if (r_index == c_IDX_W'(i)) r_key[i*DATA_W +: DATA_W] <= HWDATA;
                        end
                    end
                    c_RGN_NONCE: begin
                        for (int i = 0; i < NONCE_WORDS; i++) begin
                            if (r_index == c_IDX_W'(i)) r_nonce[i*DATA_W +: DATA_W] <= HWDATA;
                        end
                    end
                    c_RGN_DEST: begin
                        r_dest <= HWDATA;
                    end
                    default: begin
                        for (int i = 0; i < TEXT_WORDS; i++) begin
                            if (r_index == c_IDX_W'(i)) r_text[i*DATA_W +: DATA_W] <= HWDATA;
                        end
                    end
                endcase
            end
        end
    end

    assign key         = r_key;
    assign nonce       = r_nonce;
    assign destination = r_dest;
    assign plain_text  = r_text;
    assign text_valid  = r_text_valid;

endmodule
`default_nettype wire
